// File: rtl/kamikaze_rvc_expander.sv
// kamikaze_rvc_expander: RV32C expander stage with output reg + skid buffer.
// Define KAMIKAZE_RVC_EN to build RV32C expansion; else 16-bit words are illegal.
module kamikaze_rvc_expander #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] ir_i,
   input  logic [31:0] pc_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [31:0] ir_o,
   output logic [31:0] pc_o,
   output logic        compressed_o,
   output logic        illegal_o,
   output logic        valid_o,
   input  logic        ready_i,
   input  logic        flush_i
);

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic        cmp;
      logic        ill;
   } ent_t;

   localparam ent_t RST_ENT = '{
      ir:  32'h0000_0013,
      pc:  RESET_PC,
      cmp: 1'b0,
      ill: 1'b0
   };

   logic        is_c;
   logic [31:0] exp_ir;
   logic        exp_ill;
   ent_t        in_ent;
   ent_t        or_q;
   ent_t        sr_q;
   logic        or_valid;
   logic        sr_valid;
   logic        accept;
   logic        pop;

   assign is_c = (ir_i[1:0] != 2'b11);

`ifdef KAMIKAZE_RVC_EN
   logic [15:0] c;
   logic [4:0]  rd;
   logic [4:0]  rs2;
   logic [4:0]  rdp;
   logic [4:0]  rs1p;
   logic [11:0] imm6;
   logic [11:0] a16;
   logic [20:1] jimm;
   logic [12:1] bimm;
   logic        bad;

   assign c    = ir_i[15:0];
   assign rd   = c[11:7];
   assign rs2  = c[6:2];
   assign rdp  = {2'b01, c[4:2]};
   assign rs1p = {2'b01, c[9:7]};
   assign imm6 = {{6{c[12]}}, c[12], c[6:2]};
   assign a16  = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
   assign jimm = {{9{c[12]}}, c[12], c[8], c[10:9], c[6],
                  c[7], c[2], c[11], c[5:3]};
   assign bimm = {{4{c[12]}}, c[12], c[6:5], c[2],
                  c[11:10], c[4:3]};

   always_comb begin
      exp_ir = ir_i;
      bad    = 1'b0;
      if (is_c) begin
         exp_ir = {16'h0, c};
         unique case ({c[15:13], c[1:0]})
            5'b000_00: begin
               exp_ir = {2'b00, c[10:7], c[12:11], c[5], c[6],
                         2'b00, 5'd2, 3'b000, rdp, 7'h13};
               bad    = (c[12:5] == 8'h00);
            end
            5'b010_00:
               exp_ir = {5'b0, c[5], c[12:10], c[6], 2'b00,
                         rs1p, 3'b010, rdp, 7'h03};
            5'b110_00:
               exp_ir = {5'b0, c[5], c[12], rdp, rs1p, 3'b010,
                         c[11:10], c[6], 2'b00, 7'h23};
            5'b000_01:
               exp_ir = {imm6, rd, 3'b000, rd, 7'h13};
            5'b001_01, 5'b101_01:
               exp_ir = {jimm[20], jimm[10:1], jimm[11],
                         jimm[19:12], 4'b0, ~c[15], 7'h6f};
            5'b010_01:
               exp_ir = {imm6, 5'd0, 3'b000, rd, 7'h13};
            5'b011_01: begin
               bad = ({c[12], c[6:2]} == 6'd0);
               if (rd == 5'd2)
                  exp_ir = {a16, 5'd2, 3'b000, 5'd2, 7'h13};
               else
                  exp_ir = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
            end
            5'b100_01: begin
               unique case (c[11:10])
                  2'b00: begin
                     exp_ir = {7'h00, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                     bad    = c[12];
                  end
                  2'b01: begin
                     exp_ir = {7'h20, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                     bad    = c[12];
                  end
                  2'b10:
                     exp_ir = {imm6, rs1p, 3'b111, rs1p, 7'h13};
                  default: begin
                     bad = c[12];
                     unique case (c[6:5])
                        2'b00:   exp_ir = {7'h20, rdp, rs1p, 3'b000, rs1p, 7'h33};
                        2'b01:   exp_ir = {7'h00, rdp, rs1p, 3'b100, rs1p, 7'h33};
                        2'b10:   exp_ir = {7'h00, rdp, rs1p, 3'b110, rs1p, 7'h33};
                        default: exp_ir = {7'h00, rdp, rs1p, 3'b111, rs1p, 7'h33};
                     endcase
                  end
               endcase
            end
            5'b110_01, 5'b111_01:
               exp_ir = {bimm[12], bimm[10:5], 5'd0, rs1p, 2'b00, c[13],
                         bimm[4:1], bimm[11], 7'h63};
            5'b000_10: begin
               exp_ir = {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
               bad    = c[12];
            end
            5'b010_10: begin
               exp_ir = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
                         5'd2, 3'b010, rd, 7'h03};
               bad    = (rd == 5'd0);
            end
            5'b100_10: begin
               if (!c[12] && rs2 == 5'd0) begin
                  exp_ir = {12'h0, rd, 3'b000, 5'd0, 7'h67};
                  bad    = (rd == 5'd0);
               end else if (!c[12]) begin
                  exp_ir = {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
               end else if (rs2 == 5'd0 && rd == 5'd0) begin
                  exp_ir = 32'h0010_0073;
               end else if (rs2 == 5'd0) begin
                  exp_ir = {12'h0, rd, 3'b000, 5'd1, 7'h67};
               end else begin
                  exp_ir = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
               end
            end
            5'b110_10:
               exp_ir = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
                         c[11:9], 2'b00, 7'h23};
            default:
               bad = 1'b1;
         endcase
         if (bad)
            exp_ir = {16'h0, c};
      end
      exp_ill = bad;
   end
`else
   always_comb begin
      exp_ir  = is_c ? {16'h0, ir_i[15:0]} : ir_i;
      exp_ill = is_c;
   end
`endif

   assign in_ent = '{ir: exp_ir, pc: pc_i, cmp: is_c, ill: exp_ill};
   assign ready_o = ~sr_valid;
   assign accept  = valid_i & ready_o;
   assign pop     = or_valid & ready_i;

   // accept and pop-with-SR-full are exclusive since ready_o is low then
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         or_valid <= 1'b0;
         sr_valid <= 1'b0;
         or_q     <= RST_ENT;
         sr_q     <= RST_ENT;
      end else if (flush_i) begin
         or_valid <= 1'b0;
         sr_valid <= 1'b0;
      end else if (pop && sr_valid) begin
         or_q     <= sr_q;
         sr_valid <= 1'b0;
      end else if (accept && (!or_valid || pop)) begin
         or_q     <= in_ent;
         or_valid <= 1'b1;
      end else if (accept) begin
         sr_q     <= in_ent;
         sr_valid <= 1'b1;
      end else if (pop) begin
         or_valid <= 1'b0;
      end
   end

   assign valid_o      = or_valid;
   assign ir_o         = or_q.ir;
   assign pc_o         = or_q.pc;
   assign compressed_o = or_q.cmp;
   assign illegal_o    = or_q.ill;

endmodule

// File: doc/kamikaze_rvc_expander.md
Name: kamikaze_rvc_expander

Overview:
Pipeline stage directly downstream of the instruction fetch FIFO. It accepts aligned instruction words with their PC, expands RV32C 16-bit encodings into equivalent 32-bit RV32I instructions, and flags illegal encodings. It presents the result to the decode stage through a registered valid/ready handshake with a one-entry skid buffer. It is fully flushable on a branch or jump redirect.

Parameters:
RESET_PC, 32'h0000_0000, value that pc_o takes at reset.

Ports:
clk_i  in  1  core clock, rising edge
rst_i  in  1  asynchronous reset, active-low
ir_i  in  32  instruction from fetch; compressed iff ir_i[1:0]!=2'b11, upper half ignored then
pc_i  in  32  PC of ir_i
valid_i  in  1  ir_i/pc_i valid (fetch ready_o)
ready_o  out  1  stage can accept (drives fetch fetch_ready_i)
ir_o  out  32  expanded 32-bit instruction
pc_o  out  32  PC of ir_o
compressed_o  out  1  ir_o came from a 16-bit encoding (next PC = pc_o+2)
illegal_o  out  1  encoding illegal or unsupported
valid_o  out  1  outputs valid
ready_i  in  1  decode accepts
flush_i  in  1  discard all held instructions

Behaviour:
- Reset (async, rst_i=0) sets: valid_o=0, ir_o=32'h0000_0013, pc_o=RESET_PC, compressed_o=0, illegal_o=0, ready_o=1, skid empty.
- Storage is an output register (OR) plus a skid register (SR). ready_o is registered and equals !SR_valid.
- Accept = valid_i && ready_o. Expansion is combinational on ir_i and is captured at accept.
- Latency: an instruction accepted in cycle N is visible at valid_o in cycle N+1.
- Pop = valid_o && ready_i.
- Accept, OR empty or popping, SR empty: load OR.
- Accept, OR full and not popping: load SR; ready_o=0 next cycle.
- Pop with SR full: SR moves to OR, SR empties, ready_o=1 next cycle.
- Pop with SR full plus simultaneous accept: cannot occur, because ready_o=0.
- Ordering is strictly FIFO. No instruction is duplicated or dropped except by flush.
- flush_i (highest priority): next cycle valid_o=0, SR empty, ready_o=1. An accept in the same cycle as flush is discarded.
- compressed_o=1 iff ir_i[1:0]!=2'b11. 32-bit words pass through unchanged with compressed_o=0 and illegal_o=0.
- Expansion covers the full RV32C integer set:
  - Q0: C.ADDI4SPN, C.LW, C.SW
  - Q1: C.NOP/ADDI, C.JAL, C.LI, C.ADDI16SP, C.LUI, C.SRLI, C.SRAI, C.ANDI, C.SUB, C.XOR, C.OR, C.AND, C.J, C.BEQZ, C.BNEZ
  - Q2: C.SLLI, C.LWSP, C.JR, C.MV, C.EBREAK, C.JALR, C.ADD, C.SWSP
  - Immediates are sign- or zero-extended per the ISA. rd'/rs' map to x8..x15.
- Illegal encodings (illegal_o=1, ir_o={16'h0, ir_i[15:0]}):
  - 16'h0000
  - C.ADDI4SPN with nzuimm=0
  - C.ADDI16SP with imm=0
  - C.LUI with nzimm=0
  - C.LWSP with rd=0
  - C.JR with rs1=0
  - shifts with shamt[5]=1
  - FP loads/stores (C.FLD/FLW/FSD/FSW and the SP forms)
  - reserved Q1 funct6=100111 forms
- Hint encodings (e.g. C.ADDI with rd=0 and nzimm!=0) expand normally and are not illegal.
- pc_o is a passthrough of pc_i captured with the instruction.

Optional Feature:
KAMIKAZE_RVC_EN
- Defined: full RV32C expansion as described above.
- Undefined: expansion logic compiled out. Every compressed word gives illegal_o=1, ir_o={16'h0, ir_i[15:0]}, compressed_o=1. 32-bit path and handshake are unchanged.

Test Plan:
- ir_i=32'h0000_0085 (C.ADDI x1,1), pc_i=32'h100, ready_i=1 -> next cycle valid_o=1, ir_o=32'h0010_8093, pc_o=32'h100, compressed_o=1, illegal_o=0.
- ir_i=32'h0000_4515 (C.LI a0,5) -> ir_o=32'h0050_0513; ir_i=32'h0000_0001 (C.NOP) -> ir_o=32'h0000_0013.
- ir_i=32'h00A0_0093 (32-bit ADDI) -> ir_o=32'h00A0_0093, compressed_o=0; ir_i=32'h0000_0000 -> illegal_o=1, ir_o=32'h0000_0000.
- Backpressure:
  - Stimulus: ready_i=0; push A (pc 0x0) then B (pc 0x2) on consecutive cycles.
  - Response: ready_o=0 from the cycle after B is accepted; valid_o held with A stable.
  - Release ready_i=1: A popped, then B, in order; ready_o=1 again.
- Flush: with OR and SR full, assert flush_i together with valid_i=1 (C) -> next cycle valid_o=0, ready_o=1, C never appears.
- Async reset mid-stream: drop rst_i while valid_o=1 -> valid_o=0, pc_o=RESET_PC, ready_o=1 immediately without a clock edge. After release, the first accept appears after one cycle.
